// File: rtl/chipset_pkg.sv
// rtl/chipset_pkg.sv - shared types and constants for the chipset core
// Contents:
//   bus_status_e  : 8088 S2..S0 bus status encodings
//   cyc_state_e   : bus cycle sequencer states
//   PORT_*        : decoded I/O port addresses (address[9:0])
//   inta_vector() : interrupt vector for the lowest active IRQ
package chipset_pkg;

  typedef enum logic [2:0] {
    ST_INTA    = 3'b000,
    ST_IOR     = 3'b001,
    ST_IOW     = 3'b010,
    ST_HALT    = 3'b011,
    ST_CODE    = 3'b100,
    ST_MEMR    = 3'b101,
    ST_MEMW    = 3'b110,
    ST_PASSIVE = 3'b111
  } bus_status_e;

  typedef enum logic [1:0] {
    CYC_IDLE,
    CYC_ALE,
    CYC_CMD
  } cyc_state_e;

  localparam logic [9:0] PORT_IRQ_MASK = 10'h021;
  localparam logic [9:0] PORT_A        = 10'h060;
  localparam logic [9:0] PORT_B        = 10'h061;
  localparam logic [9:0] PORT_C        = 10'h062;
  localparam logic [9:0] PORT_MODE     = 10'h063;

  // Lowest-numbered active request wins; 8'h0F doubles as the spurious vector.
  function automatic logic [7:0] inta_vector(input logic [7:0] active);
    logic [7:0] vec;
    vec = 8'h0F;
    for (int i = 7; i >= 0; i--) begin
      if (active[i]) vec = 8'h08 + 8'(i);
    end
    return vec;
  endfunction

endpackage

// File: rtl/chipset_if.sv
// rtl/chipset_if.sv - CPU-side bus bundle between the 8088 and the chipset
// Signals:
//   cpu_address, cpu_data_bus, processor_status, processor_lock_n : from CPU
//   io_channel_ready : external ready, processor_ready : ready to CPU
//   address, data_bus, address_latch_enable : latched bus outputs
//   io_read_n, io_write_n, memory_read_n, memory_write_n : bus commands
interface chipset_if;
  logic [19:0] cpu_address;
  logic [7:0]  cpu_data_bus;
  logic [2:0]  processor_status;
  logic        processor_lock_n;
  logic        io_channel_ready;
  logic        processor_ready;
  logic [19:0] address;
  logic [7:0]  data_bus;
  logic        address_latch_enable;
  logic        io_read_n;
  logic        io_write_n;
  logic        memory_read_n;
  logic        memory_write_n;

  modport master (
    output cpu_address, cpu_data_bus, processor_status, processor_lock_n, io_channel_ready,
    input  processor_ready, address, data_bus, address_latch_enable,
    input  io_read_n, io_write_n, memory_read_n, memory_write_n
  );

  modport slave (
    input  cpu_address, cpu_data_bus, processor_status, processor_lock_n, io_channel_ready,
    output processor_ready, address, data_bus, address_latch_enable,
    output io_read_n, io_write_n, memory_read_n, memory_write_n
  );
endinterface

// File: rtl/ps2_receiver.sv
// rtl/ps2_receiver.sv - PS/2 keyboard frame receiver
// Ports:
//   clock, reset_n     : system clock, async active-low reset
//   ps2_clock/ps2_data : raw keyboard lines (synchronized here)
//   hold               : clears scancode/pending and keeps receiver idle
//   scancode, pending  : last accepted byte and its not-yet-cleared flag
module ps2_receiver #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ps2_clock,
  input  logic       ps2_data,
  input  logic       hold,
  output logic [7:0] scancode,
  output logic       pending
);
  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   clk_prev_q;
  logic [9:0]             shift_q;
  logic [3:0]             bit_cnt_q;
  logic                   clk_s;
  logic                   data_s;
  logic                   fall;
  logic                   frame_ok;

  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];
  assign fall   = clk_prev_q & ~clk_s;
  // Evaluated while the stop bit is on data_s: shift_q[0]=start,
  // shift_q[8:1]=data, shift_q[9]=parity (odd over data+parity).
  assign frame_ok = ~shift_q[0] & data_s & (^shift_q[9:1]);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      scancode    <= '0;
      pending     <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clock};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
      clk_prev_q  <= clk_s;
      if (hold) begin
        scancode  <= '0;
        pending   <= 1'b0;
        bit_cnt_q <= '0;
      end else if (fall) begin
        if (bit_cnt_q == 4'd10) begin
          bit_cnt_q <= '0;
          if (frame_ok && !pending) begin
            scancode <= shift_q[8:1];
            pending  <= 1'b1;
          end
        end else begin
          shift_q   <= {data_s, shift_q[9:1]};
          bit_cnt_q <= bit_cnt_q + 4'd1;
        end
      end
    end
  end
endmodule

// File: rtl/chipset_core.sv
// rtl/chipset_core.sv - 8088 bus controller, interrupt mask/vector, PPI and keyboard port
// Optional feature: PS2_KEYBOARD_EN adds the PS/2 receiver on port A / IRQ1.
// Ports:
//   clock, reset_n          : system clock, async active-low reset
//   bus (chipset_if.slave)  : CPU address/data/status in, latched address, ALE,
//                             bus commands and data_bus out
//   interrupt_request/_to_cpu : level IRQ0..7 in, INTR out
//   port_c_in, port_b_out, speaker_out : PPI ports
//   ps2_clock, ps2_data     : keyboard serial lines
module chipset_core
  import chipset_pkg::*;
#(
  parameter int PS2_SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  chipset_if.slave    bus,
  input  logic [7:0]  interrupt_request,
  output logic        interrupt_to_cpu,
  input  logic [7:0]  port_c_in,
  output logic [7:0]  port_b_out,
  output logic        speaker_out,
  input  logic        ps2_clock,
  input  logic        ps2_data
);
  cyc_state_e  state_q, state_d;
  bus_status_e status, status_q, cyc_type_q;
  logic [19:0] address_q;
  logic [7:0]  wdata_q, mask_q, port_b_q, mode_q;
  logic [7:0]  scancode, irq_active, io_rdata, data_bus_d;
  logic        kbd_pending, start, commit, in_cmd;
  logic [9:0]  io_addr;

  assign status  = bus_status_e'(bus.processor_status);
  assign io_addr = address_q[9:0];
  assign in_cmd  = (state_q == CYC_CMD);

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    commit  = 1'b0;
    case (state_q)
      CYC_IDLE: if (status_q == ST_PASSIVE && status != ST_PASSIVE) begin
        state_d = CYC_ALE;
        start   = 1'b1;
      end
      // A status that falls back to passive during T1 ends the cycle without a command.
      CYC_ALE: state_d = (status == ST_PASSIVE) ? CYC_IDLE : CYC_CMD;
      CYC_CMD: if (status == ST_PASSIVE) begin
        state_d = CYC_IDLE;
        commit  = 1'b1;
      end
      default: state_d = CYC_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= CYC_IDLE;
      status_q   <= ST_PASSIVE;
      cyc_type_q <= ST_PASSIVE;
      address_q  <= '0;
      wdata_q    <= 8'hFF;
      mask_q     <= 8'hFF;
      port_b_q   <= '0;
      mode_q     <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status;
      if (start) begin
        address_q  <= bus.cpu_address;
        cyc_type_q <= status;
      end
      if (commit && (cyc_type_q == ST_IOW || cyc_type_q == ST_MEMW)) begin
        wdata_q <= bus.cpu_data_bus;
      end
      if (commit && cyc_type_q == ST_IOW) begin
        case (io_addr)
          PORT_IRQ_MASK: mask_q   <= bus.cpu_data_bus;
          PORT_B:        port_b_q <= bus.cpu_data_bus;
          PORT_MODE:     mode_q   <= bus.cpu_data_bus;
          default: ;
        endcase
      end
    end
  end

  assign irq_active       = {interrupt_request[7:2], interrupt_request[1] | kbd_pending,
                             interrupt_request[0]} & ~mask_q;
  assign interrupt_to_cpu = |irq_active;

  always_comb begin
    io_rdata = 8'hFF;
    case (io_addr)
      PORT_IRQ_MASK: io_rdata = mask_q;
      PORT_A:        io_rdata = scancode;
      PORT_B:        io_rdata = port_b_q;
      PORT_C:        io_rdata = port_c_in;
      PORT_MODE:     io_rdata = mode_q;
      default: ;
    endcase
  end

  always_comb begin
    data_bus_d = wdata_q;
    if (in_cmd) begin
      case (cyc_type_q)
        ST_IOR:           data_bus_d = io_rdata;
        ST_INTA:          data_bus_d = inta_vector(irq_active);
        ST_CODE, ST_MEMR: data_bus_d = 8'hFF;
        default: ;
      endcase
    end
  end

  assign bus.data_bus             = data_bus_d;
  assign bus.address              = address_q;
  assign bus.address_latch_enable = (state_q == CYC_ALE);
  assign bus.io_read_n            = ~(in_cmd && cyc_type_q == ST_IOR);
  assign bus.io_write_n           = ~(in_cmd && cyc_type_q == ST_IOW);
  assign bus.memory_read_n        = ~(in_cmd && (cyc_type_q == ST_MEMR || cyc_type_q == ST_CODE));
  assign bus.memory_write_n       = ~(in_cmd && cyc_type_q == ST_MEMW);
  assign bus.processor_ready      = bus.io_channel_ready;
  assign port_b_out               = port_b_q;
  assign speaker_out              = port_b_q[1];

`ifdef PS2_KEYBOARD_EN
  ps2_receiver #(
    .SYNC_STAGES(PS2_SYNC_STAGES)
  ) u_ps2_receiver (
    .clock    (clock),
    .reset_n  (reset_n),
    .ps2_clock(ps2_clock),
    .ps2_data (ps2_data),
    .hold     (port_b_q[7]),
    .scancode (scancode),
    .pending  (kbd_pending)
  );
  logic unused_lock;
  assign unused_lock = bus.processor_lock_n;
`else
  logic                       unused_ps2;
  logic [PS2_SYNC_STAGES-1:0] unused_sync_width;
  assign scancode          = 8'h00;
  assign kbd_pending       = 1'b0;
  assign unused_ps2        = ^{ps2_clock, ps2_data, bus.processor_lock_n};
  assign unused_sync_width = '0;
`endif
endmodule

// File: tb/tb_chipset_core.sv
// tb/tb_chipset_core.sv - directed self-checking bench for chipset_core
module tb_chipset_core;
  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] interrupt_request = 8'h00;
  logic       interrupt_to_cpu;
  logic [7:0] port_c_in = 8'h00;
  logic [7:0] port_b_out;
  logic       speaker_out;
  logic       ps2_clock = 1'b1;
  logic       ps2_data = 1'b1;

  int checks = 0;
  int errors = 0;

  logic       ale_p1, ale_p2;
  logic [3:0] cmd_p2, cmd_p4, cmd_rel;
  logic [7:0] rd;
  logic [19:0] addr_p2;

  chipset_if bus();

  chipset_core #(.PS2_SYNC_STAGES(2)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .bus              (bus),
    .interrupt_request(interrupt_request),
    .interrupt_to_cpu (interrupt_to_cpu),
    .port_c_in        (port_c_in),
    .port_b_out       (port_b_out),
    .speaker_out      (speaker_out),
    .ps2_clock        (ps2_clock),
    .ps2_data         (ps2_data)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] cmds();
    return {bus.io_read_n, bus.io_write_n, bus.memory_read_n, bus.memory_write_n};
  endfunction

  // One bus cycle with status held for three command clocks, then passive.
  task automatic bus_cycle(input logic [2:0] st, input logic [19:0] a, input logic [7:0] d);
    @(posedge clock); #1;
    bus.processor_status = st;
    bus.cpu_address      = a;
    bus.cpu_data_bus     = d;
    @(posedge clock); @(negedge clock);
    ale_p1 = bus.address_latch_enable;
    @(posedge clock); @(negedge clock);
    ale_p2  = bus.address_latch_enable;
    cmd_p2  = cmds();
    rd      = bus.data_bus;
    addr_p2 = bus.address;
    @(posedge clock); @(negedge clock);
    @(posedge clock); @(negedge clock);
    cmd_p4 = cmds();
    bus.processor_status = 3'b111;
    @(posedge clock); @(negedge clock);
    cmd_rel = cmds();
  endtask

  task automatic io_read(input logic [19:0] a);
    bus_cycle(3'b001, a, 8'h00);
  endtask

  task automatic io_write(input logic [19:0] a, input logic [7:0] d);
    bus_cycle(3'b010, a, d);
  endtask

  task automatic ps2_frame(input logic [10:0] bits);
    for (int i = 0; i < 11; i++) begin
      ps2_data = bits[i];
      repeat (4) @(posedge clock);
      #1 ps2_clock = 1'b0;
      repeat (4) @(posedge clock);
      #1 ps2_clock = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (8) @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    bus.cpu_address      = '0;
    bus.cpu_data_bus     = '0;
    bus.processor_status = 3'b111;
    bus.processor_lock_n = 1'b1;
    bus.io_channel_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_ale", bus.address_latch_enable, 1'b0);
    check("rst_cmds", cmds(), 4'b1111);
    check("rst_addr", bus.address, 20'h0);
    check("rst_data", bus.data_bus, 8'hFF);
    check("rst_portb", port_b_out, 8'h00);
    check("rst_intr", interrupt_to_cpu, 1'b0);
    check("ready_hi", bus.processor_ready, 1'b1);
    bus.io_channel_ready = 1'b0;
    #1 check("ready_lo", bus.processor_ready, 1'b0);
    reset_n = 1'b1;

    io_write(20'h00061, 8'h55);
    check("iow_ale_p1", ale_p1, 1'b1);
    check("iow_ale_p2", ale_p2, 1'b0);
    check("iow_addr", addr_p2, 20'h00061);
    check("iow_cmd_p2", cmd_p2, 4'b1011);
    check("iow_cmd_p4", cmd_p4, 4'b1011);
    check("iow_cmd_rel", cmd_rel, 4'b1111);
    check("portb_55", port_b_out, 8'h55);
    check("spk_0", speaker_out, 1'b0);
    check("wdata_idle", bus.data_bus, 8'h55);

    io_read(20'h00061);
    check("ior_cmd", cmd_p2, 4'b0111);
    check("rd_portb", rd, 8'h55);
    port_c_in = 8'hCC;
    io_read(20'h00062);
    check("rd_portc", rd, 8'hCC);
    io_read(20'h00123);
    check("rd_unmapped", rd, 8'hFF);
    io_read(20'h00063);
    check("rd_mode", rd, 8'h00);
    io_read(20'h00060);
    check("rd_porta", rd, 8'h00);
    io_read(20'h00021);
    check("rd_mask_rst", rd, 8'hFF);

    io_write(20'h00021, 8'h00);
    interrupt_request = 8'h04;
    #1 check("intr_irq2", interrupt_to_cpu, 1'b1);
    bus_cycle(3'b000, 20'h00000, 8'h00);
    check("inta_cmds", cmd_p2, 4'b1111);
    check("inta_vec_0a", rd, 8'h0A);
    io_write(20'h00021, 8'h04);
    check("intr_masked", interrupt_to_cpu, 1'b0);
    io_write(20'h00021, 8'h10);
    interrupt_request = 8'h30;
    bus_cycle(3'b000, 20'h00000, 8'h00);
    check("inta_vec_0d", rd, 8'h0D);
    interrupt_request = 8'h00;
    bus_cycle(3'b000, 20'h00000, 8'h00);
    check("inta_vec_none", rd, 8'h0F);
    io_write(20'h00021, 8'hFD);
    interrupt_request = 8'h02;
    #1 check("intr_irq1_line", interrupt_to_cpu, 1'b1);
    interrupt_request = 8'h00;
    #1 check("intr_irq1_off", interrupt_to_cpu, 1'b0);

    bus_cycle(3'b011, 20'h0ABCD, 8'h00);
    check("halt_ale", ale_p1, 1'b1);
    check("halt_cmd_p2", cmd_p2, 4'b1111);
    check("halt_cmd_p4", cmd_p4, 4'b1111);

    bus_cycle(3'b110, 20'h12345, 8'h3C);
    check("memw_addr", addr_p2, 20'h12345);
    check("memw_cmd_p4", cmd_p4, 4'b1110);
    check("memw_rel", cmd_rel, 4'b1111);
    check("memw_data", bus.data_bus, 8'h3C);
    bus_cycle(3'b101, 20'hF0000, 8'h00);
    check("memr_cmd", cmd_p2, 4'b1101);
    check("memr_data", rd, 8'hFF);

    io_write(20'h00061, 8'h02);
    check("spk_1", speaker_out, 1'b1);

    // Abort an IRQ mask write mid-command; the mask must stay at its reset value.
    @(posedge clock); #1;
    bus.processor_status = 3'b010;
    bus.cpu_address      = 20'h00021;
    bus.cpu_data_bus     = 8'h00;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    bus.processor_status = 3'b111;
    #1 check("abort_cmds", cmds(), 4'b1111);
    @(negedge clock);
    reset_n = 1'b1;
    interrupt_request = 8'h01;
    repeat (2) @(negedge clock);
    check("abort_no_commit", interrupt_to_cpu, 1'b0);
    check("abort_portb", port_b_out, 8'h00);
    interrupt_request = 8'h00;

`ifdef PS2_KEYBOARD_EN
    io_write(20'h00021, 8'hFD);
    ps2_frame(11'b11010101010);
    check("kbd_intr", interrupt_to_cpu, 1'b1);
    io_read(20'h00060);
    check("kbd_porta", rd, 8'h55);
    bus_cycle(3'b000, 20'h00000, 8'h00);
    check("kbd_inta", rd, 8'h09);
    io_write(20'h00061, 8'h80);
    io_write(20'h00061, 8'h00);
    check("kbd_clr_intr", interrupt_to_cpu, 1'b0);
    io_read(20'h00060);
    check("kbd_clr_porta", rd, 8'h00);
    ps2_frame(11'b10010101010);
    check("kbd_bad_parity", interrupt_to_cpu, 1'b0);
    ps2_frame(11'b11010101010);
    check("kbd_recover", interrupt_to_cpu, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/chipset_core.md
CHIPSET_CORE -- requirements
Module: chipset_core

Interface
REQ-001 Parameter PS2_SYNC_STAGES, default 2: synchronizer flops on ps2_clock/ps2_data (minimum 2).
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 clock  in  1  system clock; all state changes on rising edge.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 cpu_address  in  20  CPU multiplexed address, valid while processor_status leaves 3'b111.
REQ-006 cpu_data_bus  in  8  CPU write data.
REQ-007 processor_status  in  3  8088 S2..S0 status.
REQ-008 processor_lock_n  in  1  bus lock; ignored, reserved.
REQ-009 processor_ready  out  1  equals io_channel_ready.
REQ-010 io_channel_ready  in  1  external ready.
REQ-011 interrupt_request  in  8  level IRQ0..7.
REQ-012 interrupt_to_cpu  out  1  INTR.
REQ-013 address  out  20  latched bus address.
REQ-014 data_bus  out  8  read/INTA data to CPU, else latched write data.
REQ-015 address_latch_enable  out  1  ALE.
REQ-016 io_read_n, io_write_n, memory_read_n, memory_write_n  out  1 each  active-low bus commands.
REQ-017 port_c_in  in  8  PPI port C inputs.
REQ-018 port_b_out  out  8  PPI port B register.
REQ-019 speaker_out  out  1  port_b_out[1].
REQ-020 ps2_clock, ps2_data  in  1 each  keyboard serial lines.

Function
REQ-021 Cycle start: status_q==3'b111 and status!=3'b111 -> ALE high exactly one cycle, address latched from cpu_address on that edge.
REQ-022 Command asserted the cycle after ALE, held while status!=111, released on the first edge after status returns to 111.
REQ-023 Decode: 000 INTA, 001 IOR, 010 IOW, 011 halt (no command), 100/101 MEMR, 110 MEMW.
REQ-024 I/O write commits on the releasing edge using latched address and cpu_data_bus; only address[9:0] decoded.
REQ-025 I/O map: 0x021 IRQ mask (R/W); 0x060 port A scancode (R); 0x061 port B (R/W); 0x062 port_c_in (R); 0x063 PPI mode (R/W); any other I/O read returns 8'hFF.
REQ-026 interrupt_to_cpu = OR over i of (irq_i & ~mask[i]), where irq1 = interrupt_request[1] | kbd_pending.
REQ-027 INTA drives data_bus = 8'h08 + index of lowest-numbered active unmasked IRQ; 8'h0F if none.
REQ-028 Memory cycles produce commands only; data_bus = 8'hFF during MEMR.
REQ-029 PS/2: sample ps2_data on synchronized ps2_clock falling edge; frame = start 0, 8 data LSB first, odd parity, stop 1.
REQ-030 Valid frame with kbd_pending=0 and port_b_out[7]=0: scancode loaded, kbd_pending set.
REQ-031 Bad start/parity/stop, or frame completing while kbd_pending=1: frame discarded, bit counter cleared.
REQ-032 port_b_out[7]=1: scancode cleared to 0, kbd_pending cleared, receiver held idle.

Reset
REQ-033 Reset: ALE 0, all commands 1, address 0, data_bus 8'hFF, port_b_out 0, mode 0, mask 8'hFF, scancode 0, kbd_pending 0, receiver idle, status_q 3'b111.
REQ-034 Reset asserted mid-cycle aborts the cycle; no pending write commits.

Configuration
REQ-035 Macro PS2_KEYBOARD_EN defined: REQ-029..032 present. Undefined: no receiver, port A reads 8'h00, IRQ1 from interrupt_request[1] only.

Structure
REQ-036 Package chipset_pkg holds the bus-status enum and the I/O port address constants.
REQ-037 Sub-module ps2_receiver (synchronizer, shift register, frame check), instantiated under PS2_KEYBOARD_EN.

Verification
REQ-038 Write 0x061=8'h55, read 0x061 -> data_bus 8'h55, speaker_out 0; io_write_n low 3 cycles after ALE.
REQ-039 port_c_in=8'hCC, read 0x062 -> 8'hCC; read 0x123 -> 8'hFF.
REQ-040 Mask=0, interrupt_request=8'h04 -> interrupt_to_cpu 1; INTA -> 8'h0A; mask=8'h04 -> interrupt_to_cpu 0.
REQ-041 PS/2 frame 0,1,0,1,0,1,0,1,0,1,1 -> port A 8'h55, IRQ1, INTA 8'h09; write 0x061=8'h80 then 8'h00 -> interrupt_to_cpu 0, port A 8'h00.
REQ-042 Status 011 -> ALE pulses once, no command asserts; status 110 -> memory_write_n low until status returns to 111.
